// File: rtl/alert_pkg.sv
// Shared types and helpers for the detect alert controller.
package alert_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BEEP    = 2'd1,
    HOLDOFF = 2'd2
  } alert_state_t;

  // Bits needed to hold an unsigned counter whose largest value is maxv (at least 1).
  function automatic int cnt_w(input int maxv);
    return (maxv < 2) ? 1 : $clog2(maxv + 1);
  endfunction

endpackage

// File: rtl/detect_alert_ctrl_tone_gen.sv
// Square-wave tone generator: toggles every 'half' enabled cycles, restarts low when disabled.
module tone_gen
  import alert_pkg::*;
#(
  parameter int HW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic [HW-1:0] half,
  output logic          sq
);

  logic [HW-1:0] cnt;

  // Half-period counter; the output flips as the counter wraps.
  always_ff @(posedge clk) begin
    if (reset || !en) begin
      cnt <= '0;
      sq  <= 1'b0;
    end else if (cnt == half - HW'(1)) begin
      cnt <= '0;
      sq  <= ~sq;
    end else begin
      cnt <= cnt + HW'(1);
    end
  end

endmodule

// File: rtl/detect_alert_ctrl.sv
// Alert controller after the word detector: confirms repeated hits per channel,
// then plays a channel-specific tone, followed by a hold-off window.
// Optional macro DETECT_ALERT_MUTE_EN adds mute_in, which silences beep only.
module detect_alert_ctrl
  import alert_pkg::*;
#(
  parameter int NCH            = 2,
  parameter int CONFIRM        = 2,
  parameter int BEEP_CYCLES    = 50000000,
  parameter int HOLDOFF_CYCLES = 25000000,
  parameter int TONE_HALF      = 6250,
  parameter int TONE_STEP      = 1250,
  localparam int AW            = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           dv_in,
  input  logic [NCH-1:0] hit_in,
  input  logic           vad_in,
`ifdef DETECT_ALERT_MUTE_EN
  input  logic           mute_in,
`endif
  output logic           beep,
  output logic           alert_active,
  output logic [AW-1:0]  alert_id,
  output logic [NCH-1:0] led_hit,
  output logic           led_vad
);

  localparam int CW       = cnt_w(CONFIRM);
  localparam int DW       = cnt_w(BEEP_CYCLES - 1);
  localparam int HOLD_MAX = (HOLDOFF_CYCLES > 0) ? HOLDOFF_CYCLES - 1 : 0;
  localparam int OW       = cnt_w(HOLD_MAX);
  localparam int HALF_MAX = TONE_HALF + (NCH - 1) * TONE_STEP;
  localparam int HW       = cnt_w(HALF_MAX);

  alert_state_t            state, state_nxt;
  logic [NCH-1:0][CW-1:0]  conf_q, conf_nxt;
  logic [NCH-1:0]          reach;
  logic                    fire;
  logic [AW-1:0]           fire_id;
  logic [HW-1:0]           fire_half, half_q;
  logic [DW-1:0]           dur_q;
  logic [OW-1:0]           hold_q;
  logic                    tone_sq;

  // Per-channel next confirm count (saturating) and which channels reach CONFIRM now.
  always_comb begin
    conf_nxt = conf_q;
    reach    = '0;
    for (int k = 0; k < NCH; k++) begin
      if (dv_in) begin
        if (!hit_in[k])                     conf_nxt[k] = '0;
        else if (conf_q[k] != CW'(CONFIRM)) conf_nxt[k] = conf_q[k] + CW'(1);
      end
      reach[k] = dv_in && hit_in[k] && (conf_nxt[k] == CW'(CONFIRM));
    end
  end

  // Fire arbitration: lowest reaching channel wins and picks its tone.
  always_comb begin
    fire      = (state == IDLE) && (|reach);
    fire_id   = '0;
    fire_half = HW'(TONE_HALF);
    for (int k = NCH - 1; k >= 0; k--) begin
      if (reach[k]) begin
        fire_id   = AW'(k);
        fire_half = HW'(TONE_HALF + k * TONE_STEP);
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (fire) state_nxt = BEEP;
      BEEP:    if (dur_q == DW'(BEEP_CYCLES - 1))
                 state_nxt = (HOLDOFF_CYCLES == 0) ? IDLE : HOLDOFF;
      HOLDOFF: if (hold_q == OW'(HOLD_MAX)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Timers, confirm counters, alert bookkeeping and LED capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      dur_q    <= '0;
      hold_q   <= '0;
      conf_q   <= '0;
      alert_id <= '0;
      half_q   <= HW'(TONE_HALF);
      led_hit  <= '0;
      led_vad  <= 1'b0;
    end else begin
      dur_q  <= (state == BEEP && state_nxt == BEEP) ? dur_q + DW'(1) : '0;
      hold_q <= (state == HOLDOFF && state_nxt == HOLDOFF) ? hold_q + OW'(1) : '0;
      // Counters only move in IDLE; a fire clears them so the next alert starts fresh.
      if (state == IDLE && dv_in) conf_q <= fire ? '0 : conf_nxt;
      if (fire) begin
        alert_id <= fire_id;
        half_q   <= fire_half;
      end
      led_vad <= vad_in;
      if (dv_in) led_hit <= hit_in;
    end
  end

  tone_gen #(.HW(HW)) u_tone (
    .clk   (clk),
    .reset (reset),
    .en    (state == BEEP),
    .half  (half_q),
    .sq    (tone_sq)
  );

  // Outputs: tone is gated by the beep window so it drops the moment the alert ends.
  always_comb begin
    alert_active = (state == BEEP);
`ifdef DETECT_ALERT_MUTE_EN
    beep = tone_sq && alert_active && !mute_in;
`else
    beep = tone_sq && alert_active;
`endif
  end

endmodule

// File: tb/tb_detect_alert_ctrl.sv
// Scoreboard bench for detect_alert_ctrl: stimulus queues expected alerts, a monitor
// measures each alert (id, length, beep rise times) as it appears.
module tb_detect_alert_ctrl;

  localparam int BC = 100;
  localparam int HC = 50;
  localparam int TH = 5;
  localparam int TS = 2;

  typedef struct {
    int id;
    int half;
    bit muted;
    int len;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset, dv_in, vad_in;
  logic [1:0] hit_in;
  logic       beep, alert_active, led_vad;
  logic [0:0] alert_id;
  logic [1:0] led_hit;
  // Second instance: no hold-off, short beep.
  logic       dv2;
  logic [1:0] hit2;
  logic       beep2, active2, vad2_led;
  logic [0:0] id2;
  logic [1:0] led_hit2;
`ifdef DETECT_ALERT_MUTE_EN
  logic       mute_in;
`endif

  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  detect_alert_ctrl #(.NCH(2), .CONFIRM(2), .BEEP_CYCLES(BC), .HOLDOFF_CYCLES(HC),
                      .TONE_HALF(TH), .TONE_STEP(TS)) dut (
    .clk(clk), .reset(reset), .dv_in(dv_in), .hit_in(hit_in), .vad_in(vad_in),
`ifdef DETECT_ALERT_MUTE_EN
    .mute_in(mute_in),
`endif
    .beep(beep), .alert_active(alert_active), .alert_id(alert_id),
    .led_hit(led_hit), .led_vad(led_vad)
  );

  detect_alert_ctrl #(.NCH(2), .CONFIRM(2), .BEEP_CYCLES(20), .HOLDOFF_CYCLES(0),
                      .TONE_HALF(TH), .TONE_STEP(TS)) dut_h0 (
    .clk(clk), .reset(reset), .dv_in(dv2), .hit_in(hit2), .vad_in(1'b0),
`ifdef DETECT_ALERT_MUTE_EN
    .mute_in(1'b0),
`endif
    .beep(beep2), .alert_active(active2), .alert_id(id2),
    .led_hit(led_hit2), .led_vad(vad2_led)
  );

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, req);
    end
  endtask

  // Drive one dv_in strobe; returns 1 time unit after the sampling edge.
  task automatic pulse(input logic [1:0] h);
    dv_in = 1'b1; hit_in = h;
    @(posedge clk); #1;
    dv_in = 1'b0; hit_in = 2'b00;
  endtask

  task automatic pulse2(input logic [1:0] h);
    dv2 = 1'b1; hit2 = h;
    @(posedge clk); #1;
    dv2 = 1'b0; hit2 = 2'b00;
  endtask

  task automatic gap(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_alert(input int id, input int half, input bit muted, input int len);
    exp_t e;
    e.id = id; e.half = half; e.muted = muted; e.len = len;
    exp_q.push_back(e);
  endtask

  // Monitor: measures every alert window and compares with the queued expectation.
  bit   in_alert = 1'b0;
  bit   prev_beep;
  int   mj, r1, r2;
  exp_t cur;
  always @(negedge clk) begin
    if (alert_active) begin
      if (!in_alert) begin
        in_alert = 1'b1; mj = 0; r1 = -1; r2 = -1; prev_beep = 1'b0;
        if (exp_q.size() == 0) begin
          chk("unexpected_alert", 1, 0);
          cur.len = 0;
        end else begin
          cur = exp_q.pop_front();
          chk("alert_id", int'(alert_id), cur.id);
        end
      end
      if (beep && !prev_beep) begin
        if (r1 < 0) r1 = mj;
        else if (r2 < 0) r2 = mj;
      end
      prev_beep = beep;
      mj++;
    end else if (in_alert) begin
      in_alert = 1'b0;
      chk("beep_low_at_fall", int'(beep), 0);
      if (cur.len > 0) begin
        chk("alert_len", mj, cur.len);
        chk("first_rise", r1, cur.muted ? -1 : cur.half);
        chk("second_rise", r2, cur.muted ? -1 : 3 * cur.half);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL timeout actual running required finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; dv_in = 1'b0; hit_in = '0; vad_in = 1'b0; dv2 = 1'b0; hit2 = '0;
`ifdef DETECT_ALERT_MUTE_EN
    mute_in = 1'b0;
`endif
    gap(3);
    reset = 1'b0;
    chk("rst_beep", int'(beep), 0);
    chk("rst_active", int'(alert_active), 0);
    chk("rst_id", int'(alert_id), 0);
    chk("rst_led_hit", int'(led_hit), 0);
    chk("rst_led_vad", int'(led_vad), 0);

    vad_in = 1'b1; gap(1); chk("led_vad_hi", int'(led_vad), 1);
    vad_in = 1'b0; gap(1); chk("led_vad_lo", int'(led_vad), 0);

    // 1: two channel-0 hits fire channel 0
    pulse(2'b01);
    chk("led_hit_01", int'(led_hit), 1);
    gap(3);
    expect_alert(0, TH, 1'b0, BC);
    pulse(2'b01);
    chk("active_next_cycle", int'(alert_active), 1);
    gap(160);

    // 2: hit, miss, hit -> nothing; one more hit -> alert
    pulse(2'b01); gap(2);
    pulse(2'b00); gap(2);
    chk("led_hit_held_miss", int'(led_hit), 0);
    pulse(2'b01); gap(20);
    expect_alert(0, TH, 1'b0, BC);
    pulse(2'b01); gap(160);

    // 3: tie goes to channel 0; then channel 1 alone
    expect_alert(0, TH, 1'b0, BC);
    pulse(2'b11); pulse(2'b11); gap(160);
    expect_alert(1, TH + TS, 1'b0, BC);
    pulse(2'b10); gap(1); pulse(2'b10); gap(160);
    chk("alert_id_held", int'(alert_id), 1);

    // 4: hits during BEEP and HOLDOFF are ignored but still shown on led_hit
    expect_alert(0, TH, 1'b0, BC);
    pulse(2'b01); pulse(2'b01);
    gap(10);
    pulse(2'b10);
    chk("led_hit_in_beep", int'(led_hit), 2);
    pulse(2'b10); pulse(2'b11);
    gap(100);
    pulse(2'b10); pulse(2'b10);
    gap(50);
    pulse(2'b10); gap(20);
    expect_alert(1, TH + TS, 1'b0, BC);
    pulse(2'b10); gap(160);

    // 5: reset at beep cycle 40 aborts the alert
    expect_alert(0, TH, 1'b0, 41);
    pulse(2'b01); pulse(2'b01);
    gap(40);
    reset = 1'b1; gap(1); reset = 1'b0;
    chk("abort_active", int'(alert_active), 0);
    chk("abort_beep", int'(beep), 0);
    chk("abort_led_hit", int'(led_hit), 0);
    gap(3);
    pulse(2'b01); gap(20);
    expect_alert(0, TH, 1'b0, BC);
    pulse(2'b01); gap(160);

`ifdef DETECT_ALERT_MUTE_EN
    // 6: muted alert keeps its timing but stays silent
    mute_in = 1'b1;
    expect_alert(0, TH, 1'b1, BC);
    pulse(2'b01); pulse(2'b01); gap(160);
    mute_in = 1'b0;
`endif

    // No hold-off build: IDLE directly after the beep, fresh hits fire again at once
    pulse2(2'b10); pulse2(2'b10);
    chk("h0_active", int'(active2), 1);
    chk("h0_id", int'(id2), 1);
    gap(19);
    chk("h0_active_last", int'(active2), 1);
    gap(1);
    chk("h0_active_end", int'(active2), 0);
    chk("h0_beep_end", int'(beep2), 0);
    pulse2(2'b01); pulse2(2'b01);
    chk("h0_refire", int'(active2), 1);
    chk("h0_refire_id", int'(id2), 0);
    gap(30);

    chk("queue_empty", exp_q.size(), 0);
    chk("monitor_idle", int'(in_alert), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
